// File: rtl/input_capture_pkg.sv
`default_nettype none
// ============================================================================
// Package : ic_pkg
// Brief   : Shared widths, capture FSM states and saturating helpers for the
//           input_capture block.
// Rev     : 1.0  initial release
// ============================================================================
package ic_pkg;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FALL = 2'd1,
    WAIT_RISE = 2'd2
  } state_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Sum of two counts, clamped to the all-ones value on overflow.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_capture_if.sv
`default_nettype none
// ============================================================================
// Interface : input_capture_if
// Brief     : Measured input pin plus the timing results and done strobe.
// Rev       : 1.0  initial release
// ============================================================================
interface input_capture_if;
  import ic_pkg::*;

  logic             signal_in;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] low_time;
  logic [CNT_W-1:0] period_time;
  logic             measurement_done;

  // Side that owns the pin and consumes the results.
  modport master (
    output signal_in,
    input  high_time,
    input  low_time,
    input  period_time,
    input  measurement_done
  );

  // Measurement block.
  modport slave (
    input  signal_in,
    output high_time,
    output low_time,
    output period_time,
    output measurement_done
  );

endinterface
`default_nettype wire

// File: rtl/input_capture_sync_edge.sv
`default_nettype none
// ============================================================================
// Module : input_sync_edge
// Brief  : Multi-flop synchronizer for an asynchronous input followed by one
//          history register, giving single-cycle rise/fall pulses.
// Rev    : 1.0  initial release
// ============================================================================
module input_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the pin through the synchronizer chain and keep the last synced value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync_out = r_sync[SYNC_STAGES-1];
  assign rise     =  r_sync[SYNC_STAGES-1] & ~r_prev;
  assign fall     = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/input_capture.sv
`default_nettype none
// ============================================================================
// Module : input_capture
// Brief  : Measures high time, low time and period of an asynchronous square
//          wave in system clock cycles; pulses measurement_done per period and
//          clears results when the input stops toggling.
// Rev    : 1.0  initial release
// ============================================================================
module input_capture
  import ic_pkg::*;
#(
  parameter int          CLOCK_FREQ     = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2 * CLOCK_FREQ,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic clk,
  input  logic rst,
  input_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT_CYCLES);

  logic             w_sync_unused;
  logic             w_rise;
  logic             w_fall;
  logic             w_timeout;
  logic             w_cap_high;
  logic             w_cap_low;
  logic [CNT_W-1:0] w_cnt_cap;
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_high_cap;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_low;
  logic [CNT_W-1:0] r_period;
  logic             r_done;

  input_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.signal_in),
    .sync_out (w_sync_unused),
    .rise     (w_rise),
    .fall     (w_fall)
  );

  // The value captured at an edge includes the edge cycle itself.
  assign w_cnt_cap = sat_inc(r_cnt);
  // Silence is only meaningful once a measurement has started.
  assign w_timeout = (r_state != IDLE) && (r_cnt >= c_timeout);

  // Edge-to-edge cycle counter, restarted by either edge and saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_rise || w_fall) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  // Capture FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture FSM next-state logic; timeout dominates any coincident edge.
  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:      if (w_rise) w_next = WAIT_FALL;
        WAIT_FALL: if (w_fall) w_next = WAIT_RISE;
        WAIT_RISE: if (w_rise) w_next = WAIT_FALL;
        default:   w_next = IDLE;
      endcase
    end
  end

  // Capture FSM outputs: which edge loads which measurement.
  always_comb begin
    w_cap_high = 1'b0;
    w_cap_low  = 1'b0;
    if (!w_timeout) begin
      w_cap_high = (r_state == WAIT_FALL) && w_fall;
      w_cap_low  = (r_state == WAIT_RISE) && w_rise;
    end
  end

  // High time is held privately until the closing rise so all three results
  // change together with the done strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_high_cap <= '0;
      r_high     <= '0;
      r_low      <= '0;
      r_period   <= '0;
      r_done     <= 1'b0;
    end else if (w_timeout) begin
      r_high_cap <= '0;
      r_high     <= '0;
      r_low      <= '0;
      r_period   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_cap_low;
      if (w_cap_high) begin
        r_high_cap <= w_cnt_cap;
      end
      if (w_cap_low) begin
        r_high   <= r_high_cap;
        r_low    <= w_cnt_cap;
        r_period <= sat_add(r_high_cap, w_cnt_cap);
      end
    end
  end

  assign bus.high_time        = r_high;
  assign bus.low_time         = r_low;
  assign bus.period_time      = r_period;
  assign bus.measurement_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_input_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_input_capture
// Brief  : Directed self-checking bench for input_capture with a shortened
//          timeout (CLOCK_FREQ=1000 -> 2000-cycle timeout).
// Rev    : 1.0  initial release
// ============================================================================
module tb_input_capture;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n_done;
  logic r_prev_done;
  logic r_b2b;
  int   snap;

  input_capture_if bus ();

  input_capture #(
    .CLOCK_FREQ  (1000),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Count done pulses and flag any pulse that lasts two cycles.
  always @(negedge clk) begin
    if (!rst) begin
      r_prev_done <= 1'b0;
    end else begin
      r_prev_done <= bus.measurement_done;
      if (bus.measurement_done) n_done <= n_done + 1;
      if (bus.measurement_done && r_prev_done) r_b2b <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive a level for n clocks, changing only on falling clock edges.
  task automatic hold(input logic level, input int n);
    bus.signal_in = level;
    repeat (n) @(negedge clk);
  endtask

  // Raise the input and expect done exactly on the third clock, with results.
  task automatic rise_check(input string tag, input int h, input int l);
    bus.signal_in = 1'b1;
    @(negedge clk); check({tag, "_lat1"}, {31'd0, bus.measurement_done}, 32'd0);
    @(negedge clk); check({tag, "_lat2"}, {31'd0, bus.measurement_done}, 32'd0);
    @(negedge clk); check({tag, "_done"}, {31'd0, bus.measurement_done}, 32'd1);
    check({tag, "_high"},   bus.high_time,   h);
    check({tag, "_low"},    bus.low_time,    l);
    check({tag, "_period"}, bus.period_time, h + l);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_high"},   bus.high_time,   32'd0);
    check({tag, "_low"},    bus.low_time,    32'd0);
    check({tag, "_period"}, bus.period_time, 32'd0);
    check({tag, "_done"},   {31'd0, bus.measurement_done}, 32'd0);
  endtask

  task automatic done_delta(input string tag, input int exp);
    #2;
    check(tag, n_done - snap, exp);
    snap = n_done;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_done = 0; r_b2b = 1'b0; r_prev_done = 1'b0;
    rst = 1'b0;
    bus.signal_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // 50% duty, 50-cycle halves: five rises, first one only arms the FSM.
    snap = n_done;
    hold(1'b0, 10);
    for (int i = 0; i < 4; i++) begin
      hold(1'b1, 50);
      hold(1'b0, 50);
    end
    hold(1'b1, 5);
    done_delta("d50_count", 4);
    check("d50_high",   bus.high_time,   32'd50);
    check("d50_low",    bus.low_time,    32'd50);
    check("d50_period", bus.period_time, 32'd100);

    // Frequency step to 10-cycle halves: no gap, new period reported at once.
    hold(1'b1, 45);
    hold(1'b0, 50);
    hold(1'b1, 10);
    hold(1'b0, 10);
    rise_check("step", 10, 10);
    hold(1'b1, 7);
    done_delta("step_count", 2);

    // 25% duty: 25 high / 75 low, done three clocks after the rise.
    hold(1'b0, 75);
    hold(1'b1, 25);
    hold(1'b0, 75);
    rise_check("d25", 25, 75);
    hold(1'b1, 22);
    done_delta("d25_count", 2);

    // Timeout: results survive just under the limit, clear after it.
    hold(1'b0, 1990);
    check("pre_to_high", bus.high_time, 32'd25);
    hold(1'b0, 110);
    check_zero("timeout");
    done_delta("to_count", 0);
    hold(1'b1, 30);
    hold(1'b0, 30);
    done_delta("reacq_none", 0);
    rise_check("reacq", 30, 30);
    done_delta("reacq_count", 1);

    // One-clock glitch gives high_time=1 and period to the next rise.
    hold(1'b1, 27);
    hold(1'b0, 40);
    hold(1'b1, 1);
    hold(1'b0, 40);
    rise_check("glitch", 1, 40);
    hold(1'b1, 5);
    hold(1'b0, 10);
    done_delta("glitch_count", 2);

    // Sub-clock pulse between sampling edges: never seen, nothing unknown.
    bus.signal_in = 1'b1;
    #3;
    bus.signal_in = 1'b0;
    hold(1'b0, 10);
    check("sub_x", {31'd0, $isunknown({bus.high_time, bus.low_time,
                                       bus.period_time, bus.measurement_done})}, 32'd0);
    check("sub_period", bus.period_time, 32'd41);
    done_delta("sub_count", 0);

    // Reset in the middle of a measurement, then full re-acquisition.
    hold(1'b1, 20);
    rst = 1'b0;
    bus.signal_in = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("mid_rst");
    rst = 1'b1;
    snap = n_done;
    hold(1'b0, 10);
    hold(1'b1, 20);
    hold(1'b0, 20);
    done_delta("post_rst_none", 0);
    rise_check("post_rst", 20, 20);
    done_delta("post_rst_count", 1);
    hold(1'b1, 10);

    check("no_b2b", {31'd0, r_b2b}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
